// File: rtl/ex_pkg.sv
// Shared definitions for the EX stage: operation codes, result classes,
// divider state encoding and common constants.
package ex_pkg;

  localparam logic       RST_ENABLE = 1'b1;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // Result class selected by ID
  localparam logic [2:0] RES_NOP   = 3'b000;
  localparam logic [2:0] RES_LOGIC = 3'b001;
  localparam logic [2:0] RES_SHIFT = 3'b010;
  localparam logic [2:0] RES_ARITH = 3'b100;

  // Operation subtype selected by ID
  localparam logic [7:0] OP_NOP  = 8'b0000_0000;
  localparam logic [7:0] OP_AND  = 8'b0010_0100;
  localparam logic [7:0] OP_OR   = 8'b0010_0101;
  localparam logic [7:0] OP_XOR  = 8'b0010_0110;
  localparam logic [7:0] OP_NOR  = 8'b0010_0111;
  localparam logic [7:0] OP_SLL  = 8'b0111_1100;
  localparam logic [7:0] OP_SRL  = 8'b0000_0010;
  localparam logic [7:0] OP_SRA  = 8'b0000_0011;
  localparam logic [7:0] OP_ADDU = 8'b0010_0001;
  localparam logic [7:0] OP_SUBU = 8'b0010_0011;
  localparam logic [7:0] OP_SLT  = 8'b0010_1010;
  localparam logic [7:0] OP_SLTU = 8'b0010_1011;
  localparam logic [7:0] OP_DIV  = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU = 8'b0001_1011;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_div.sv
// Restoring divider: one quotient bit per cycle, signed or unsigned.
// result = {remainder, quotient}, valid for the single cycle ready is high.
module div
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        start,
  input  logic        annul,
  output logic [63:0] result,
  output logic        ready
);

  div_state_e  state_d, state_q;
  logic [4:0]  cnt_d, cnt_q;
  logic [31:0] dvd_d, dvd_q;
  logic [31:0] dvs_d, dvs_q;
  logic [31:0] rem_d, rem_q;
  logic        qneg_d, qneg_q;
  logic        rneg_d, rneg_q;
  logic [63:0] result_d, result_q;
  logic        ready_d, ready_q;

  logic [32:0] rem_sh, diff;
  logic        qbit;
  logic [31:0] rem_next, quot_next;

  // dvd_q doubles as the quotient shift register while dividing
  assign rem_sh    = {rem_q, dvd_q[31]};
  assign diff      = rem_sh - {1'b0, dvs_q};
  assign qbit      = ~diff[32];
  assign rem_next  = qbit ? diff[31:0] : rem_sh[31:0];
  assign quot_next = {dvd_q[30:0], qbit};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = '0;
    ready_d  = 1'b0;
    case (state_q)
      DIV_FREE: begin
        if (start) begin
          if (op2 == ZERO_WORD) begin
            state_d = DIV_BYZERO;
            dvd_d   = op1;
          end else begin
            state_d = DIV_ON;
            cnt_d   = '0;
            rem_d   = '0;
            dvd_d   = signed_div ? abs32(op1) : op1;
            dvs_d   = signed_div ? abs32(op2) : op2;
            qneg_d  = signed_div & (op1[31] ^ op2[31]);
            rneg_d  = signed_div & op1[31];
          end
        end
      end
      DIV_BYZERO: begin
        state_d  = DIV_END;
        ready_d  = 1'b1;
        result_d = {dvd_q, 32'hFFFF_FFFF};
      end
      DIV_ON: begin
        dvd_d = quot_next;
        rem_d = rem_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d  = DIV_END;
          ready_d  = 1'b1;
          result_d = {rneg_q ? (~rem_next + 32'd1) : rem_next,
                      qneg_q ? (~quot_next + 32'd1) : quot_next};
        end
      end
      DIV_END: state_d = DIV_FREE;
      default: state_d = DIV_FREE;
    endcase
    if (annul) begin
      state_d  = DIV_FREE;
      ready_d  = 1'b0;
      result_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q  <= DIV_FREE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result = result_q;
  assign ready  = ready_q;

endmodule

// File: rtl/ex.sv
// EX stage: single-cycle logic/shift/arith ops plus optional multi-cycle
// divider enabled by the EX_DIV_EN macro (DIV/DIVU act as NOP without it).
module ex
  import ex_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        aluop_i,
  input  logic [2:0]        alusel_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic              annul_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              whilo_o,
  output logic              stallreq_o
);

  logic [31:0] logic_res, shift_res, arith_res, res;
  logic        is_div;

  assign is_div = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);

  always_comb begin
    logic_res = ZERO_WORD;
    shift_res = ZERO_WORD;
    arith_res = ZERO_WORD;
    case (aluop_i)
      OP_OR:   logic_res = reg1_i | reg2_i;
      OP_AND:  logic_res = reg1_i & reg2_i;
      OP_XOR:  logic_res = reg1_i ^ reg2_i;
      OP_NOR:  logic_res = ~(reg1_i | reg2_i);
      OP_SLL:  shift_res = reg2_i << reg1_i[4:0];
      OP_SRL:  shift_res = reg2_i >> reg1_i[4:0];
      OP_SRA:  shift_res = $signed(reg2_i) >>> reg1_i[4:0];
      OP_ADDU: arith_res = reg1_i + reg2_i;
      OP_SUBU: arith_res = reg1_i - reg2_i;
      OP_SLT:  arith_res = {31'b0, $signed(reg1_i) < $signed(reg2_i)};
      OP_SLTU: arith_res = {31'b0, reg1_i < reg2_i};
      default: ;
    endcase
    case (alusel_i)
      RES_LOGIC: res = logic_res;
      RES_SHIFT: res = shift_res;
      RES_ARITH: res = arith_res;
      default:   res = ZERO_WORD;
    endcase
  end

  assign wd_o    = rst ? 5'd0 : wd_i;
  assign wreg_o  = rst ? 1'b0 : (wreg_i & ~is_div);
  assign wdata_o = rst ? ZERO_WORD : res;

`ifdef EX_DIV_EN
  logic [63:0] div_result;
  logic        div_ready;

  div u_div (
    .clk        (clk),
    .rst        (rst),
    .signed_div (aluop_i == OP_DIV),
    .op1        (reg1_i),
    .op2        (reg2_i),
    .start      (is_div & ~annul_i),
    .annul      (annul_i),
    .result     (div_result),
    .ready      (div_ready)
  );

  // Upstream holds the divide op during the stall, so is_div stays high
  // until the result cycle releases the pipeline.
  assign stallreq_o = ~rst & ~annul_i & is_div & ~div_ready;
  assign whilo_o    = ~rst & ~annul_i & div_ready;
  assign hi_o       = whilo_o ? div_result[63:32] : ZERO_WORD;
  assign lo_o       = whilo_o ? div_result[31:0]  : ZERO_WORD;
`else
  logic unused_div_inputs;
  assign unused_div_inputs = ^{clk, annul_i};
  assign stallreq_o = 1'b0;
  assign whilo_o    = 1'b0;
  assign hi_o       = ZERO_WORD;
  assign lo_o       = ZERO_WORD;
`endif

endmodule

// File: tb/tb_ex.sv
// Self-checking bench for ex: directed and random ALU ops against a
// behavioural model; divider sequences when EX_DIV_EN is defined.
module tb_ex;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i, reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i, annul_i;
  logic [4:0]  wd_o;
  logic        wreg_o, whilo_o, stallreq_o;
  logic [31:0] wdata_o, hi_o, lo_o;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  ex #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .annul_i(annul_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o), .stallreq_o(stallreq_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: operation class and result from the arithmetic rules
  function automatic logic [2:0] op_class(input logic [7:0] op);
    if (op == OP_OR || op == OP_AND || op == OP_XOR || op == OP_NOR) return RES_LOGIC;
    if (op == OP_SLL || op == OP_SRL || op == OP_SRA) return RES_SHIFT;
    if (op == OP_ADDU || op == OP_SUBU || op == OP_SLT || op == OP_SLTU) return RES_ARITH;
    return RES_NOP;
  endfunction

  function automatic logic [31:0] model_alu(input logic [2:0] sel, input logic [7:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
    int sa;
    longint sga, sgb;
    sa  = int'(a[4:0]);
    sga = longint'($signed(a));
    sgb = longint'($signed(b));
    if (sel == RES_NOP || op_class(op) != sel) return 32'h0;
    case (op)
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SLL:  return b << sa;
      OP_SRL:  return b >> sa;
      OP_SRA:  return (b >> sa) | (b[31] ? ~(32'hFFFF_FFFF >> sa) : 32'h0);
      OP_ADDU: return a + b;
      OP_SUBU: return a - b;
      OP_SLT:  return (sga < sgb) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [63:0] model_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!sgn) return {a % b, a / b};
    q = longint'($signed(a)) / longint'($signed(b));
    r = longint'($signed(a)) % longint'($signed(b));
    return {r[31:0], q[31:0]};
  endfunction

  task automatic drive(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] wd, input logic wreg);
    alusel_i = sel;
    aluop_i  = op;
    reg1_i   = a;
    reg2_i   = b;
    wd_i     = wd;
    wreg_i   = wreg;
  endtask

  task automatic alu_case(input string tag, input logic [2:0] sel, input logic [7:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    logic [4:0] wd;
    logic wr;
    wd = 5'($urandom_range(0, 31));
    wr = 1'($urandom_range(0, 1));
    drive(sel, op, a, b, wd, wr);
    exp_q.push_back({32'h0, exp});
    @(negedge clk);
    check(tag, {32'h0, wdata_o}, exp_q.pop_front());
    check({tag, "_wd"}, {58'h0, wreg_o, wd_o}, {58'h0, wr, wd});
    @(posedge clk); #1;
  endtask

  task automatic div_case(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int stalls;
    logic done, bad;
    stalls = 0; done = 1'b0; bad = 1'b0;
    drive(RES_NOP, sgn ? OP_DIV : OP_DIVU, a, b, 5'd3, 1'b1);
`ifdef EX_DIV_EN
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (stallreq_o) begin
        stalls++;
        if (whilo_o || wreg_o || hi_o != 0 || lo_o != 0) bad = 1'b1;
        @(posedge clk); #1;
      end else begin
        done = 1'b1;
      end
    end
    check({tag, "_done"}, {63'h0, done}, 64'd1);
    check({tag, "_stalls"}, 64'(stalls), (b == 32'd0) ? 64'd2 : 64'd33);
    check({tag, "_quiet"}, {63'h0, bad}, 64'd0);
    check({tag, "_whilo"}, {62'h0, whilo_o, wreg_o}, 64'd2);
    check({tag, "_hilo"}, {hi_o, lo_o}, model_div(sgn, a, b));
    @(posedge clk); #1;
    drive(RES_NOP, OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    @(negedge clk);
    check({tag, "_after"}, {whilo_o, stallreq_o, hi_o, lo_o}, 66'h0);
`else
    @(negedge clk);
    check({tag, "_nodiv"}, {29'h0, stallreq_o, whilo_o, wreg_o, wdata_o}, 64'h0);
`endif
    @(posedge clk); #1;
    drive(RES_NOP, OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  logic [2:0]  tbl_sel[11] = '{RES_LOGIC, RES_LOGIC, RES_LOGIC, RES_LOGIC, RES_SHIFT, RES_SHIFT,
                               RES_SHIFT, RES_ARITH, RES_ARITH, RES_ARITH, RES_ARITH};
  logic [7:0]  tbl_op[11]  = '{OP_OR, OP_AND, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA,
                               OP_ADDU, OP_SUBU, OP_SLT, OP_SLTU};
  logic [31:0] edge_v[5]   = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

  function automatic logic [31:0] rnd_val();
    if ($urandom_range(0, 3) == 0) return edge_v[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    logic bad;
    rst = 1'b1;
    annul_i = 1'b0;
    drive(RES_LOGIC, OP_OR, 32'h1234_5678, 32'h0F0F_0000, 5'd7, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {wd_o, wreg_o, whilo_o, stallreq_o, wdata_o}, 64'h0);
    check("reset_hilo", {hi_o, lo_o}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed single-cycle cases
    drive(RES_LOGIC, OP_OR, 32'h0000_F0F0, 32'h0000_0F0F, 5'd5, 1'b1);
    @(negedge clk);
    check("or_data", {32'h0, wdata_o}, 64'h0000_FFFF);
    check("or_wd", {58'h0, wreg_o, wd_o}, {58'h0, 1'b1, 5'd5});
    @(posedge clk); #1;
    alu_case("sra", RES_SHIFT, OP_SRA, 32'd4, 32'h8000_0000, 32'hF800_0000);
    alu_case("slt", RES_ARITH, OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
    alu_case("sltu", RES_ARITH, OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
    alu_case("addu_wrap", RES_ARITH, OP_ADDU, 32'hFFFF_FFFF, 32'd2, 32'd1);
    alu_case("subu_wrap", RES_ARITH, OP_SUBU, 32'd0, 32'd1, 32'hFFFF_FFFF);
    alu_case("sll31", RES_SHIFT, OP_SLL, 32'd31, 32'd3, 32'h8000_0000);
    alu_case("nor", RES_LOGIC, OP_NOR, 32'h0F0F_0000, 32'h0000_00FF, 32'hF0F0_FF00);
    alu_case("nop_sel", RES_NOP, OP_OR, 32'hFFFF_0000, 32'h0000_FFFF, 32'h0);
    alu_case("bad_op", RES_LOGIC, 8'hFF, 32'hFFFF_0000, 32'h0000_FFFF, 32'h0);

    // Random single-cycle ops against the model
    for (int i = 0; i < 60; i++) begin
      int k;
      logic [31:0] a, b;
      k = $urandom_range(0, 10);
      a = rnd_val();
      b = rnd_val();
      alu_case("rand_alu", tbl_sel[k], tbl_op[k], a, b, model_alu(tbl_sel[k], tbl_op[k], a, b));
    end

    // Divides
    div_case("divu_100_7", 1'b0, 32'd100, 32'd7);
    div_case("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    div_case("div_5_0", 1'b1, 32'd5, 32'd0);
    div_case("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    div_case("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] b;
      b = ($urandom_range(0, 4) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 300)));
      div_case("rand_div", 1'($urandom_range(0, 1)), rnd_val(), b);
    end

`ifdef EX_DIV_EN
    // Annul mid-divide: no result, pipeline released, next divide is clean
    drive(RES_NOP, OP_DIVU, 32'hFFFF_FFFF, 32'd3, 5'd1, 1'b1);
    repeat (11) @(posedge clk);
    #1 annul_i = 1'b1;
    @(negedge clk);
    check("annul_cycle", {62'h0, stallreq_o, whilo_o}, 64'h0);
    @(posedge clk); #1;
    annul_i = 1'b0;
    drive(RES_NOP, OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (whilo_o || stallreq_o) bad = 1'b1;
    end
    check("annul_quiet", {63'h0, bad}, 64'h0);
    @(posedge clk); #1;
    div_case("divu_9_3", 1'b0, 32'd9, 32'd3);

    // Reset mid-divide
    drive(RES_NOP, OP_DIVU, 32'd100, 32'd7, 5'd2, 1'b1);
    repeat (21) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outs", {wd_o, wreg_o, whilo_o, stallreq_o, wdata_o}, 64'h0);
    check("rst_mid_hilo", {hi_o, lo_o}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(RES_NOP, OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    @(negedge clk);
    check("rst_free", {62'h0, stallreq_o, whilo_o}, 64'h0);
    @(posedge clk); #1;
    div_case("divu_after_rst", 1'b0, 32'd100, 32'd7);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex.md
EX -- requirements
Module: ex

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, single clock, all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port aluop_i, input, 8, operation subtype from ID.
REQ-005 SHALL have port alusel_i, input, 3, operation class from ID (NOP/LOGIC/SHIFT/ARITH).
REQ-006 SHALL have ports reg1_i, reg2_i, input, 32, operands already resolved by ID forwarding.
REQ-007 SHALL have ports wd_i, input, 5, and wreg_i, input, 1, destination address and write enable.
REQ-008 SHALL have port annul_i, input, 1, cancels an in-flight divide.
REQ-009 SHALL have ports wd_o, output, 5; wreg_o, output, 1; wdata_o, output, 32; GPR write-back info, also fed back to ID as ex_wd/ex_wreg/ex_wdata.
REQ-010 SHALL have ports hi_o, lo_o, output, 32, and whilo_o, output, 1, HI/LO write.
REQ-011 SHALL have port stallreq_o, output, 1, pipeline stall request to control.

Function
REQ-012 SHALL compute single-cycle ops combinationally (0-cycle latency into the EX/MEM register): OR, AND, XOR, NOR; SLL, SRL, SRA (amount reg1_i[4:0], value reg2_i); ADDU, SUBU mod 2^32; SLT signed, SLTU unsigned (result 1 or 0).
REQ-013 SHALL select wdata_o by alusel_i; RES_NOP or unknown aluop gives wdata_o = 0.
REQ-014 SHALL pass wd_o = wd_i and wreg_o = wreg_i unchanged; wreg_o = 0 for DIV/DIVU.
REQ-015 SHALL implement DIV (signed) and DIVU (unsigned) with a divider FSM: states FREE, BYZERO, ON, END.
REQ-016 FREE: on DIV/DIVU with annul_i = 0 latch operands; divisor 0 -> BYZERO, else -> ON with counter 0; stallreq_o = 1.
REQ-017 ON: one restoring quotient bit per cycle, counter 0..31; after counter 31 -> END; stallreq_o = 1.
REQ-018 BYZERO: one cycle, result lo = 32'hFFFF_FFFF, hi = dividend; -> END; stallreq_o = 1.
REQ-019 END: stallreq_o = 0, whilo_o = 1, lo_o = quotient, hi_o = remainder for exactly one cycle; -> FREE.
REQ-020 Signed: divide magnitudes; quotient negated if operand signs differ; remainder takes sign of dividend; 0x80000000 / -1 gives lo = 0x80000000, hi = 0.
REQ-021 Latency: nonzero divisor -> stallreq_o high 33 cycles, result on cycle 34; zero divisor -> stallreq_o high 2 cycles, result on cycle 3.
REQ-022 Upstream SHALL hold aluop_i/reg1_i/reg2_i stable while stallreq_o = 1; ex relies on the latched copy only.
REQ-023 annul_i = 1 in any state: next state FREE, whilo_o = 0, stallreq_o = 0 that cycle; annul wins over a simultaneous new divide.
REQ-024 whilo_o = 0 and hi_o = lo_o = 0 outside END.

Reset
REQ-025 rst = 1 at a clock edge: FSM -> FREE, counter and dividend/divisor/quotient registers -> 0, including mid-divide.
REQ-026 While rst = 1 outputs SHALL be wd_o = 0, wreg_o = 0, wdata_o = 0, hi_o = lo_o = 0, whilo_o = 0, stallreq_o = 0.

Configuration
REQ-027 Macro EX_DIV_EN defined: divider FSM and REQ-015..REQ-023 present.
REQ-028 EX_DIV_EN undefined: no divider logic; DIV/DIVU behave as NOP (wdata_o = 0, wreg_o = 0, whilo_o = 0); stallreq_o tied 0.

Structure
REQ-029 aluop/alusel codes, divider state encodings, ZeroWord, RstEnable and bus-width macros SHALL live in the shared defines include.
REQ-030 Divider SHALL be sub-module div (ports clk, rst, signed_div, op1, op2, start, annul, result[63:0], ready); ex instantiates it under EX_DIV_EN.

Verification
REQ-031 OR 0x0000_F0F0 | 0x0000_0F0F, wd_i = 5, wreg_i = 1 -> same cycle wdata_o = 0x0000_FFFF, wd_o = 5, wreg_o = 1.
REQ-032 SRA, reg1_i = 4, reg2_i = 0x8000_0000 -> wdata_o = 0xF800_0000; SLT -1 vs 1 -> 1; SLTU -> 0.
REQ-033 DIVU 100 / 7 -> stallreq_o high 33 cycles, then one cycle whilo_o = 1, lo_o = 14, hi_o = 2.
REQ-034 DIV -7 / 2 -> lo_o = 0xFFFF_FFFD, hi_o = 0xFFFF_FFFF; DIV 5 / 0 -> after 2 stall cycles lo_o = 0xFFFF_FFFF, hi_o = 5.
REQ-035 Start DIVU, assert annul_i at ON cycle 10 -> next cycle stallreq_o = 0, whilo_o never pulses; new DIVU 9 / 3 then yields lo_o = 3, hi_o = 0.
REQ-036 rst = 1 at ON cycle 20 -> FREE, all outputs 0; build without EX_DIV_EN -> DIVU 100 / 7 gives stallreq_o = 0, whilo_o = 0.
